// File: rtl/carrier_detector.sv
// rtl/carrier_detector.sv - windowed I/Q square-wave carrier detector with magnitude and on/off DETECT
// Define CARRIER_DETECTOR_HYST_EN for a two-threshold (THRESH/THRESH_LO) hysteretic DETECT decision.
module carrier_detector #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BIN_STEP  = 10000,
  parameter int unsigned WINDOW    = 100000,
  parameter int unsigned THRESH    = 50000,
  parameter int unsigned THRESH_LO = 30000,
  localparam int unsigned W        = $clog2(WINDOW) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [6:0] bin_i,
  input  logic       rx_i,
  output logic [W:0] mag_o,
  output logic       valid_o,
  output logic       detect_o
);

  localparam int unsigned CW = $clog2(WINDOW);
  localparam logic [63:0] STEP_INC_WIDE = ((64'(BIN_STEP) << 32) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  localparam logic [31:0] STEP_INC = STEP_INC_WIDE[31:0];
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic signed [W:0] ACC_P1 = {{W{1'b0}}, 1'b1};
  localparam logic signed [W:0] ACC_M1 = {(W+1){1'b1}};
  localparam logic [W:0] TH_SET = (W+1)'(THRESH);
`ifdef CARRIER_DETECTOR_HYST_EN
  localparam logic [W:0] TH_CLR = (W+1)'(THRESH_LO);
`endif

  if (WINDOW < 16 || THRESH_LO > THRESH) begin : g_param_check
    $error("carrier_detector: WINDOW must be >= 16 and THRESH_LO <= THRESH");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rst_sync_q;
  logic [1:0]            rx_sync_q;
  logic [31:0]           inc_q, inc_d;
  logic [31:0]           phase_q, phase_d;
  logic signed [W:0]     acc_i_q, acc_i_d;
  logic signed [W:0]     acc_q_q, acc_q_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W:0]            mag_q, mag_d;
  logic                  detect_q, detect_d;

  logic                  x_s, iref, qref, last_sample;
  logic signed [W:0]     neg_i, neg_q;
  logic [W-1:0]          abs_i, abs_q;
  logic [W:0]            mag_sum;

  // Synchronisers: reset release and the raw comparator pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
      rx_sync_q  <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      rx_sync_q  <= {rx_sync_q[0], rx_i};
    end
  end

  assign x_s         = rx_sync_q[1];
  assign iref        = phase_q[31];
  assign qref        = phase_q[31] ^ phase_q[30];
  assign last_sample = (state_q == S_RUN) && en_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_i && rst_sync_q[1]) state_d = S_LOAD;
      S_LOAD:  state_d = en_i ? S_RUN : S_IDLE;
      S_RUN: begin
        if (!en_i)                  state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DUMP;
      end
      S_DUMP:  state_d = en_i ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == S_DUMP);
  end

  always_comb begin
    inc_d   = inc_q;
    phase_d = phase_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    if (state_q == S_LOAD) begin
      inc_d   = ({25'd0, bin_i} + 32'd1) * STEP_INC;
      phase_d = 32'd0;
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      acc_i_d = acc_i_q + ((x_s == iref) ? ACC_P1 : ACC_M1);
      acc_q_d = acc_q_q + ((x_s == qref) ? ACC_P1 : ACC_M1);
      phase_d = phase_q + inc_q;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Magnitude uses the post-last-sample accumulators so MAG is fresh while VALID is high.
  always_comb begin
    neg_i    = -acc_i_d;
    neg_q    = -acc_q_d;
    abs_i    = acc_i_d[W] ? neg_i[W-1:0] : acc_i_d[W-1:0];
    abs_q    = acc_q_d[W] ? neg_q[W-1:0] : acc_q_d[W-1:0];
    mag_sum  = {1'b0, abs_i} + {1'b0, abs_q};
    mag_d    = mag_q;
    detect_d = detect_q;
    if (last_sample) begin
      mag_d = mag_sum;
`ifdef CARRIER_DETECTOR_HYST_EN
      if (mag_sum >= TH_SET)      detect_d = 1'b1;
      else if (mag_sum < TH_CLR)  detect_d = 1'b0;
`else
      detect_d = (mag_sum >= TH_SET);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q    <= 32'd0;
      phase_q  <= 32'd0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      cnt_q    <= '0;
      mag_q    <= '0;
      detect_q <= 1'b0;
    end else begin
      inc_q    <= inc_d;
      phase_q  <= phase_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      detect_q <= detect_d;
    end
  end

  assign mag_o    = mag_q;
  assign detect_o = detect_q;

endmodule

// File: tb/tb_carrier_detector.sv
// tb/tb_carrier_detector.sv - directed self-checking bench for carrier_detector
module tb_carrier_detector;

  localparam int WINDOW = 1000;
  localparam int MW     = $clog2(WINDOW) + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic [6:0]    bin_i;
  logic          rx_i;
  logic [MW-1:0] mag_o;
  logic          valid_o;
  logic          detect_o;

  int total = 0;
  int bad   = 0;
  int period = 0;
  int on_len = 1 << 30;
  int wpos   = 0;

  carrier_detector #(
    .CLK_FREQ (1000000),
    .BIN_STEP (10000),
    .WINDOW   (WINDOW),
    .THRESH   (500),
    .THRESH_LO(300)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .bin_i   (bin_i),
    .rx_i    (rx_i),
    .mag_o   (mag_o),
    .valid_o (valid_o),
    .detect_o(detect_o)
  );

  always #5 clk = ~clk;

  // RX pattern is aligned to the window: wpos restarts on the DUMP cycle.
  initial begin
    rx_i = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_o) wpos = 0;
      else wpos++;
      rx_i = (period != 0) && (wpos < on_len) && ((wpos % period) < (period / 2));
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    check_eq($sformatf("%s(mag=%0d,lo=%0d,hi=%0d)", tag, val, lo, hi), int'(val >= lo && val <= hi), 1);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid_o && n < limit);
    check_eq("valid_seen", int'(valid_o), 1);
  endtask

  int n;
  int vcount;
  int hyst_len [3] = '{600, 400, 200};
  int hyst_lo  [3] = '{560, 360, 160};
  int hyst_hi  [3] = '{640, 440, 240};
`ifdef CARRIER_DETECTOR_HYST_EN
  int hyst_det [3] = '{1, 1, 0};
`else
  int hyst_det [3] = '{1, 0, 0};
`endif

  initial begin
    rst_n = 1'b0;
    en_i  = 1'b0;
    bin_i = 7'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_mag", int'(mag_o), 0);
    check_eq("reset_valid", int'(valid_o), 0);
    check_eq("reset_detect", int'(detect_o), 0);

    // 10 kHz carrier on bin 0
    @(negedge clk);
    rst_n  = 1'b1;
    en_i   = 1'b1;
    period = 100;
    wait_valid(1100, n);
    check_eq("first_latency", n, 1004);
    repeat (2) begin
      wait_valid(1100, n);
      check_eq("window_period", n, 1002);
      check_range("mag_10k", int'(mag_o), 900, 1100);
      check_eq("detect_10k", int'(detect_o), 1);
    end

    // reset in the middle of a window
    repeat (502) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mag", int'(mag_o), 0);
    check_eq("midrst_valid", int'(valid_o), 0);
    check_eq("midrst_detect", int'(detect_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1100, n);
    check_eq("midrst_latency", n, 1004);

    // no carrier, then an off-bin carrier
    period = 0;
    wait_valid(1100, n);
    check_range("mag_quiet", int'(mag_o), 0, 20);
    check_eq("detect_quiet", int'(detect_o), 0);
    period = 50;
    wait_valid(1100, n);
    check_range("mag_20k_bin0", int'(mag_o), 0, 40);
    check_eq("detect_20k_bin0", int'(detect_o), 0);

    // bin change mid-window applies only from the next window
    repeat (500) @(posedge clk);
    bin_i = 7'd1;
    wait_valid(1100, n);
    check_range("mag_bin_old", int'(mag_o), 0, 40);
    wait_valid(1100, n);
    check_range("mag_bin_new", int'(mag_o), 900, 1100);
    check_eq("detect_bin_new", int'(detect_o), 1);

    // on/off keying per window
    bin_i  = 7'd0;
    period = 100;
    for (int i = 0; i < 4; i++) begin
      on_len = (i % 2 == 0) ? 1000 : 0;
      wait_valid(1100, n);
      check_eq($sformatf("ook_detect_%0d", i), int'(detect_o), (i % 2 == 0) ? 1 : 0);
    end

    // partial-window carrier for threshold behaviour
    for (int i = 0; i < 3; i++) begin
      on_len = hyst_len[i];
      wait_valid(1100, n);
      check_range($sformatf("mag_part_%0d", i), int'(mag_o), hyst_lo[i], hyst_hi[i]);
      check_eq($sformatf("detect_part_%0d", i), int'(detect_o), hyst_det[i]);
    end

    // EN dropped mid-RUN: no VALID, outputs hold
    on_len = 1000;
    wait_valid(1100, n);
    check_eq("pre_abort_detect", int'(detect_o), 1);
    repeat (300) @(posedge clk);
    #1;
    en_i = 1'b0;
    vcount = 0;
    repeat (1200) begin
      @(posedge clk);
      #1;
      if (valid_o) vcount++;
    end
    check_eq("abort_valid_count", vcount, 0);
    check_eq("abort_detect_hold", int'(detect_o), 1);
    check_range("abort_mag_hold", int'(mag_o), 900, 1100);
    @(negedge clk);
    en_i = 1'b1;
    wait_valid(1100, n);
    check_eq("reenable_latency", n, 1002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
